spike_decoder: RTL



---
 rtl/spike_decoder_pkg.sv | 21 ++
 rtl/spike_evt_fifo.sv | 54 +++++
 rtl/spike_decoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/spike_decoder_pkg.sv
// Shared constants and types for the spike decoder: neuron-scaled levels,
// detector state encoding and the buffered event record.
package spike_decoder_pkg;

  localparam logic signed [7:0] THRESH_DEF = 8'sd19;
  localparam logic signed [7:0] REARM_DEF  = -8'sd16;
  // Event records carry the ISI zero-extended to this width; instances use ISI_W <= ISI_MAX_W.
  localparam int unsigned       ISI_MAX_W  = 32;

  typedef enum logic {
    ARMED = 1'b0,
    FIRED = 1'b1
  } state_t;

  typedef struct packed {
    logic [ISI_MAX_W-1:0] isi;
    logic                 first;
    logic                 sat;
  } evt_t;

endpackage

// File: rtl/spike_evt_fifo.sv
// Two-entry first-word-fall-through event buffer. A push that finds the
// buffer full with no simultaneous pop is discarded and flagged on drop.
module spike_evt_fifo
  import spike_decoder_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  evt_t push_data,
  input  logic pop,
  output evt_t head,
  output logic full,
  output logic empty,
  output logic drop
);

  evt_t       mem [0:1];
  logic       rd_ptr_reg;
  logic       wr_ptr_reg;
  logic [1:0] count_reg;
  logic       do_pop;
  logic       do_push;

  assign empty   = (count_reg == 2'd0);
  assign full    = (count_reg == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  // Stale storage is masked so the head reads as zero whenever the buffer is empty.
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/spike_decoder.sv
// Decodes a neuron membrane-voltage stream into spike pulses, buffered
// inter-spike-interval events, a windowed spike rate and a drop count.
module spike_decoder
  import spike_decoder_pkg::*;
#(
  parameter logic signed [7:0] THRESH = THRESH_DEF,
  parameter logic signed [7:0] REARM  = REARM_DEF,
  parameter int unsigned       ISI_W  = 16,
  parameter int unsigned       WINDOW = 1000,
  parameter int unsigned       CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_en,
  input  logic signed [7:0]       v_in,
  output logic                    spike,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [ISI_W-1:0]        evt_isi,
  output logic                    evt_first,
  output logic                    evt_sat,
  output logic [CNT_W-1:0]        rate_count,
  output logic                    rate_valid,
  output logic [CNT_W-1:0]        drop_count
);

  localparam int unsigned WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  state_t             state_reg;
  state_t             state_next;
  logic               spike_sample;
  logic [ISI_W-1:0]   isi_cnt_reg;
  logic [ISI_W-1:0]   isi_plus;
  logic               first_pend_reg;
  logic [WIN_W-1:0]   win_cnt_reg;
  logic [CNT_W-1:0]   win_spk_reg;
  logic [CNT_W:0]     win_sum;
  logic [CNT_W-1:0]   rate_next;
  logic [CNT_W-1:0]   rate_count_reg;
  logic               rate_valid_reg;
  logic               spike_reg;
  logic [CNT_W-1:0]   drop_count_reg;
  evt_t               push_data;
  evt_t               head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_drop;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ARMED;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    spike_sample = 1'b0;
    if (sample_en) begin
      case (state_reg)
        ARMED: if (v_in > THRESH) begin
          spike_sample = 1'b1;
          state_next   = FIRED;
        end
        FIRED: if (v_in < REARM) state_next = ARMED;
        default: state_next = ARMED;
      endcase
    end
  end

  assign isi_plus  = (isi_cnt_reg == '1) ? isi_cnt_reg : isi_cnt_reg + ISI_W'(1);
  assign win_sum   = {1'b0, win_spk_reg} + (CNT_W+1)'(spike_sample);
  assign rate_next = win_sum[CNT_W] ? '1 : win_sum[CNT_W-1:0];

  always_comb begin
    push_data       = '0;
    push_data.isi   = ISI_MAX_W'(isi_plus);
    push_data.first = first_pend_reg;
    push_data.sat   = (isi_plus == '1);
  end

  spike_evt_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (spike_sample),
    .push_data (push_data),
    .pop       (evt_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      isi_cnt_reg    <= '0;
      first_pend_reg <= 1'b1;
      win_cnt_reg    <= '0;
      win_spk_reg    <= '0;
      rate_count_reg <= '0;
      rate_valid_reg <= 1'b0;
      spike_reg      <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      spike_reg      <= spike_sample;
      rate_valid_reg <= 1'b0;
      if (fifo_drop && drop_count_reg != '1) drop_count_reg <= drop_count_reg + CNT_W'(1);
      if (sample_en) begin
        isi_cnt_reg <= spike_sample ? '0 : isi_plus;
        if (spike_sample) first_pend_reg <= 1'b0;
        // The closing sample's own spike is folded into the reported rate.
        if (win_cnt_reg == WIN_W'(WINDOW - 1)) begin
          win_cnt_reg    <= '0;
          win_spk_reg    <= '0;
          rate_count_reg <= rate_next;
          rate_valid_reg <= 1'b1;
        end else begin
          win_cnt_reg <= win_cnt_reg + WIN_W'(1);
          win_spk_reg <= rate_next;
        end
      end
    end
  end

  assign spike      = spike_reg;
  assign evt_valid  = !fifo_empty;
  assign evt_isi    = head.isi[ISI_W-1:0];
  assign evt_first  = head.first;
  assign evt_sat    = head.sat;
  assign rate_count = rate_count_reg;
  assign rate_valid = rate_valid_reg;
  assign drop_count = drop_count_reg;

endmodule
